// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word and streams it on q,
// one bit per clk, with back-to-back frames allowed from the last-bit cycle.
//
// state | meaning
// IDLE  | no frame in progress, q/q_valid low, ready for a word
// SHIFT | frame bit cnt is on q; last bit when cnt == WIDTH-1
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             last;
    logic             load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // The outgoing bit always sits at the shift-out end of shreg, so q never
    // depends combinationally on data_in.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shreg_nxt  = shreg;
        last       = (state == SHIFT) && (cnt == CNT_LAST);
        load_ready = (state == IDLE) || last;
        load       = load_valid && load_ready;
        q_valid    = (state == SHIFT);
        done       = last;
        q          = q_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

        if (load) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            shreg_nxt = data_in;
        end else if (last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end else if (state == SHIFT) begin
            cnt_nxt   = cnt + CNT_W'(1);
            shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share stimulus;
// expected bits are queued with their due cycle and checked by a monitor.
module tb_piso_serializer;

    localparam int W = 8;

    typedef struct {
        int   due;
        logic bit_v;
        logic done_v;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;
    logic         rdy0, q0, qv0, dn0;
    logic         rdy1, q1, qv1, dn1;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    exp_t sb0[$];
    exp_t sb1[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(rdy0), .q(q0), .q_valid(qv0), .done(dn0)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(rdy1), .q(q1), .q_valid(qv1), .done(dn1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue nbits of word d, first bit due in cycle start.
    task automatic push_frame(input logic [W-1:0] d, input int start, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.due    = start + i;
            e.done_v = (i == W - 1);
            e.bit_v  = d[W-1-i];
            sb0.push_back(e);
            e.bit_v  = d[i];
            sb1.push_back(e);
        end
    endtask

    task automatic mon(input int w, input logic qv, input logic qb,
                       input logic dn, input logic rdy);
        exp_t e;
        int   n;
        string tag;
        tag = (w == 0) ? "msb" : "lsb";
        n = (w == 0) ? sb0.size() : sb1.size();
        if (qv) begin
            if (n == 0) begin
                chk({tag, "_unexpected_q_valid"}, 1, 0);
            end else begin
                if (w == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk({tag, "_bit_cycle"}, cyc, e.due);
                chk({tag, "_q"}, int'(qb), int'(e.bit_v));
                chk({tag, "_done"}, int'(dn), int'(e.done_v));
                chk({tag, "_load_ready"}, int'(rdy), int'(e.done_v));
            end
        end else begin
            if (n > 0) begin
                e = (w == 0) ? sb0[0] : sb1[0];
                if (e.due <= cyc) begin
                    chk({tag, "_missing_bit"}, 0, 1);
                    if (w == 0) void'(sb0.pop_front());
                    else        void'(sb1.pop_front());
                end
            end
            chk({tag, "_idle_q"}, int'(qb), 0);
            chk({tag, "_idle_done"}, int'(dn), 0);
            chk({tag, "_idle_load_ready"}, int'(rdy), 1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, qv0, q0, dn0, rdy0);
            mon(1, qv1, q1, dn1, rdy1);
        end
    end

    initial begin
        int k;
        // Reset held for two edges, with a word offered that must be dropped.
        reset      = 1'b1;
        data_in    = 8'h5A;
        load_valid = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        chk("reset_q", int'(q0), 0);
        chk("reset_q_valid", int'(qv0), 0);
        chk("reset_done", int'(dn0), 0);
        chk("reset_load_ready", int'(rdy0), 1);
        mon_en = 1'b1;
        tick();

        // Single frame 8'hA5.
        k = cyc;
        data_in = 8'hA5; load_valid = 1'b1;
        push_frame(8'hA5, k + 1, W);
        tick();
        load_valid = 1'b0;
        repeat (9) tick();

        // Back-to-back 8'hC3 then 8'h3C; 3C is offered early and must wait.
        k = cyc;
        data_in = 8'hC3; load_valid = 1'b1;
        push_frame(8'hC3, k + 1, W);
        push_frame(8'h3C, k + 1 + W, W);
        tick();
        data_in = 8'h3C;
        repeat (8) tick();
        load_valid = 1'b0;
        repeat (9) tick();

        // 8'hFF aborted by reset during bit 4.
        k = cyc;
        data_in = 8'hFF; load_valid = 1'b1;
        push_frame(8'hFF, k + 1, 4);
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();

        // 8'h81 with data_in/load_valid disturbed while not ready.
        k = cyc;
        data_in = 8'h81; load_valid = 1'b1;
        push_frame(8'h81, k + 1, W);
        tick();
        load_valid = 1'b0;
        tick();
        data_in = 8'h00; load_valid = 1'b1;
        repeat (5) tick();
        load_valid = 1'b0;
        repeat (4) tick();

        // 8'h01: LSB-first instance gives 1 followed by seven zeros.
        k = cyc;
        data_in = 8'h01; load_valid = 1'b1;
        push_frame(8'h01, k + 1, W);
        tick();
        load_valid = 1'b0;
        repeat (10) tick();

        chk("msb_scoreboard_empty", sb0.size(), 0);
        chk("lsb_scoreboard_empty", sb1.size(), 0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select MSB-first (1) or LSB-first (0) shift order.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset, sampled on rising clk.
REQ-005 data_in  input  WIDTH  SHALL carry the parallel word to transmit.
REQ-006 load_valid  input  1  SHALL indicate that data_in holds a word to transmit.
REQ-007 load_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-008 q  output  1  SHALL carry the serial data bit.
REQ-009 q_valid  output  1  SHALL mark cycles in which q carries a frame bit.
REQ-010 done  output  1  SHALL pulse high for one cycle with the last bit of each frame.

Function
REQ-011 States SHALL be IDLE and SHIFT; a bit counter of ceil(log2(WIDTH)) bits SHALL track the bit position.
REQ-012 A load SHALL occur on a rising edge where load_valid=1 and load_ready=1; data_in SHALL be captured in a shift register on that edge.
REQ-013 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only during the last-bit cycle (counter = WIDTH-1); it SHALL be 0 otherwise.
REQ-014 The first bit SHALL appear on q with q_valid=1 in the cycle immediately after the load edge (latency 1).
REQ-015 Each subsequent bit SHALL appear on the following cycle; a frame SHALL occupy exactly WIDTH consecutive q_valid cycles.
REQ-016 The bit order SHALL be data_in[WIDTH-1] first through data_in[0] when MSB_FIRST=1, and data_in[0] first through data_in[WIDTH-1] when MSB_FIRST=0.
REQ-017 done SHALL be 1 exactly in the cycle that the last bit is on q, and 0 in every other cycle.
REQ-018 From the last-bit cycle, a load (load_valid=1) SHALL start the next frame on the following cycle with no gap (back-to-back frames).
REQ-019 From the last-bit cycle with load_valid=0, the block SHALL return to IDLE with q=0 and q_valid=0 on the next cycle.
REQ-020 In IDLE, q SHALL be 0 and q_valid SHALL be 0.
REQ-021 Changes to data_in or load_valid while load_ready=0 SHALL be ignored and SHALL NOT affect the frame in progress.
REQ-022 All outputs SHALL be driven directly from registers or state decode, with no combinational path from data_in to q.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL enter IDLE, clear the counter and shift register, and drive q=0, q_valid=0, done=0, and load_ready=1 from the next cycle.
REQ-024 Reset SHALL take priority over a simultaneous load; a word presented in the reset cycle SHALL be dropped.
REQ-025 Reset asserted mid-frame SHALL abort the frame without emitting done; no remaining bits SHALL be emitted after reset deasserts.

Verification (WIDTH=8, MSB_FIRST=1 unless stated)
REQ-026 Reset held 2 cycles, then released -> q=0, q_valid=0, done=0, load_ready=1.
REQ-027 Load 8'hA5 -> q sequence 1,0,1,0,0,1,0,1 over 8 cycles with q_valid=1, done only on the 8th cycle, and load_ready=0 on cycles 1-7.
REQ-028 Load 8'hC3 with load_valid held through the last-bit cycle carrying 8'h3C -> 16 contiguous q_valid cycles, bits 11000011 then 00111100, and done on cycles 8 and 16.
REQ-029 Load 8'hFF, then assert reset for 1 cycle on bit 4 -> q=0, q_valid=0 next cycle, no done, and idle thereafter.
REQ-030 Change data_in to 8'h00 with load_valid=1 during bits 2-6 of an 8'h81 frame -> q is still 1,0,0,0,0,0,0,1.
REQ-031 With MSB_FIRST=0, load 8'h01 -> q sequence 1,0,0,0,0,0,0,0 with done on cycle 8.
